// File: rtl/fpu_wb_sched.sv
// fpu_wb_sched: books a unique writeback cycle per FP op and muxes unit results.
// Optional FPU_WB_STALL_CNT_EN adds stall and divider-busy counters.
module fpu_wb_sched #(
  parameter int DATA_W     = 64,
  parameter int ROB_W      = 6,
  parameter int PREG_W     = 7,
  parameter int LAT_MISC   = 1,
  parameter int LAT_ADD    = 3,
  parameter int LAT_MUL    = 4,
  parameter int LAT_FMA    = 5,
  parameter int DIV_LAT_SP = 10,
  parameter int DIV_LAT_DP = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic [2:0]        op_class_i,
  input  logic              is_double_i,
  input  logic [ROB_W-1:0]  rob_id_i,
  input  logic [PREG_W-1:0] phys_dest_i,
  output logic              ready_o,
  input  logic              flush_i,
  output logic              div_start_o,
  input  logic [DATA_W-1:0] res_misc_i,
  input  logic [DATA_W-1:0] res_add_i,
  input  logic [DATA_W-1:0] res_mul_i,
  input  logic [DATA_W-1:0] res_fma_i,
  input  logic [DATA_W-1:0] res_div_i,
  input  logic [4:0]        flags_misc_i,
  input  logic [4:0]        flags_add_i,
  input  logic [4:0]        flags_mul_i,
  input  logic [4:0]        flags_fma_i,
  input  logic [4:0]        flags_div_i,
  output logic              wb_valid_o,
  output logic [DATA_W-1:0] result_o,
  output logic [4:0]        fflags_o,
  output logic [ROB_W-1:0]  rob_id_o,
  output logic [PREG_W-1:0] phys_dest_o
`ifdef FPU_WB_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       div_busy_cnt_o
`endif
);

  localparam int MAXL = LAT_FMA;
  localparam int CW   = $clog2(DIV_LAT_DP + 1);

  typedef struct packed {
    logic              v;
    logic [1:0]        cls;
    logic [ROB_W-1:0]  rob;
    logic [PREG_W-1:0] preg;
  } slot_t;

  typedef enum logic [1:0] {
    D_IDLE,
    D_BUSY,
    D_DONE
  } div_st_e;

  slot_t             slot_q [1:MAXL];
  slot_t             slot_d [1:MAXL];
  div_st_e           div_st_q, div_st_d;
  logic [CW-1:0]     div_cnt_q, div_cnt_d;
  logic [ROB_W-1:0]  div_rob_q, div_rob_d;
  logic [PREG_W-1:0] div_preg_q, div_preg_d;
  logic              div_start_q, div_start_d;
  logic              wb_valid_q, wb_valid_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [4:0]        fflags_q, fflags_d;
  logic [ROB_W-1:0]  rob_q, rob_d;
  logic [PREG_W-1:0] preg_q, preg_d;

  logic is_pipe, is_div, slot_free, accept, div_wb;
  int   lat;

  always_comb begin
    is_pipe = 1'b1;
    is_div  = 1'b0;
    lat     = 0;
    case (op_class_i)
      3'd0:    lat = LAT_MISC;
      3'd1:    lat = LAT_ADD;
      3'd2:    lat = LAT_MUL;
      3'd3:    lat = LAT_FMA;
      3'd4: begin
        is_pipe = 1'b0;
        is_div  = 1'b1;
      end
      default: is_pipe = 1'b0;
    endcase
  end

  // Slot L+1 now is slot L after this edge's shift.
  always_comb begin
    slot_free = 1'b1;
    for (int k = 1; k <= MAXL; k++)
      if (k == lat + 1 && slot_q[k].v)
        slot_free = 1'b0;
  end

  assign ready_o = (is_pipe && slot_free) ||
                   (is_div && div_st_q == D_IDLE);
  assign accept  = valid_i && ready_o && !flush_i;
  assign div_wb  = !flush_i && !slot_q[1].v &&
                   div_st_q == D_DONE;

  always_comb begin
    for (int k = 1; k < MAXL; k++)
      slot_d[k] = slot_q[k+1];
    slot_d[MAXL] = '0;
    for (int k = 1; k <= MAXL; k++) begin
      if (accept && is_pipe && k == lat) begin
        slot_d[k].v    = 1'b1;
        slot_d[k].cls  = op_class_i[1:0];
        slot_d[k].rob  = rob_id_i;
        slot_d[k].preg = phys_dest_i;
      end
      if (flush_i)
        slot_d[k] = '0;
    end
  end

  always_comb begin
    div_st_d    = div_st_q;
    div_cnt_d   = div_cnt_q;
    div_rob_d   = div_rob_q;
    div_preg_d  = div_preg_q;
    div_start_d = 1'b0;
    unique case (div_st_q)
      D_IDLE: if (accept && is_div) begin
        div_st_d    = D_BUSY;
        div_cnt_d   = is_double_i ? CW'(DIV_LAT_DP - 1)
                                  : CW'(DIV_LAT_SP - 1);
        div_rob_d   = rob_id_i;
        div_preg_d  = phys_dest_i;
        div_start_d = 1'b1;
      end
      D_BUSY: begin
        div_cnt_d = div_cnt_q - 1'b1;
        if (div_cnt_q <= CW'(1))
          div_st_d = D_DONE;
      end
      D_DONE: if (div_wb)
        div_st_d = D_IDLE;
      default: div_st_d = D_IDLE;
    endcase
    if (flush_i)
      div_st_d = D_IDLE;
  end

  // Pipelined results own slot 1; the divider only fills idle cycles.
  always_comb begin
    wb_valid_d = 1'b0;
    result_d   = result_q;
    fflags_d   = fflags_q;
    rob_d      = rob_q;
    preg_d     = preg_q;
    if (!flush_i && slot_q[1].v) begin
      wb_valid_d = 1'b1;
      rob_d      = slot_q[1].rob;
      preg_d     = slot_q[1].preg;
      unique case (slot_q[1].cls)
        2'd0: begin
          result_d = res_misc_i;
          fflags_d = flags_misc_i;
        end
        2'd1: begin
          result_d = res_add_i;
          fflags_d = flags_add_i;
        end
        2'd2: begin
          result_d = res_mul_i;
          fflags_d = flags_mul_i;
        end
        default: begin
          result_d = res_fma_i;
          fflags_d = flags_fma_i;
        end
      endcase
    end else if (div_wb) begin
      wb_valid_d = 1'b1;
      rob_d      = div_rob_q;
      preg_d     = div_preg_q;
      result_d   = res_div_i;
      fflags_d   = flags_div_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= MAXL; k++)
        slot_q[k] <= '0;
      div_st_q    <= D_IDLE;
      div_cnt_q   <= '0;
      div_rob_q   <= '0;
      div_preg_q  <= '0;
      div_start_q <= 1'b0;
      wb_valid_q  <= 1'b0;
      result_q    <= '0;
      fflags_q    <= '0;
      rob_q       <= '0;
      preg_q      <= '0;
    end else begin
      for (int k = 1; k <= MAXL; k++)
        slot_q[k] <= slot_d[k];
      div_st_q    <= div_st_d;
      div_cnt_q   <= div_cnt_d;
      div_rob_q   <= div_rob_d;
      div_preg_q  <= div_preg_d;
      div_start_q <= div_start_d;
      wb_valid_q  <= wb_valid_d;
      result_q    <= result_d;
      fflags_q    <= fflags_d;
      rob_q       <= rob_d;
      preg_q      <= preg_d;
    end
  end

  assign div_start_o = div_start_q;
  assign wb_valid_o  = wb_valid_q;
  assign result_o    = result_q;
  assign fflags_o    = fflags_q;
  assign rob_id_o    = rob_q;
  assign phys_dest_o = preg_q;

`ifdef FPU_WB_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] busy_cnt_q, busy_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    busy_cnt_d  = busy_cnt_q;
    if (valid_i && !ready_o && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + 32'd1;
    if (div_st_q != D_IDLE && busy_cnt_q != '1)
      busy_cnt_d = busy_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      busy_cnt_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      busy_cnt_q  <= busy_cnt_d;
    end
  end

  assign stall_cnt_o    = stall_cnt_q;
  assign div_busy_cnt_o = busy_cnt_q;
`endif

endmodule

// File: doc/fpu_wb_sched.md
Name: fpu_wb_sched

Overview:
Parametrised issue/writeback scheduler for the Clownfish FPU cluster. It accepts FP ops tagged with a latency class and books a unique writeback cycle for each one, so two results can never collide. It tracks the unpipelined divide/sqrt unit, muxes the per-unit result buses into one registered writeback port, and supports a full pipeline flush. Sits between the FP issue queue and the FP datapath sub-units (add, mul, fma, div/sqrt, misc).

Parameters:
DATA_W, 64, result width
ROB_W, 6, ROB id width
PREG_W, 7, physical register tag width
LAT_MISC, 1, sign-inject/move/compare/classify latency (>=1)
LAT_ADD, 3, add/sub latency
LAT_MUL, 4, multiply latency
LAT_FMA, 5, fused multiply-add latency; the largest pipelined latency, MAXL
DIV_LAT_SP, 10, single-precision div/sqrt cycles
DIV_LAT_DP, 17, double-precision div/sqrt cycles

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
valid_i  in  1  op offered
op_class_i  in  3  0=MISC 1=ADD 2=MUL 3=FMA 4=DIV; 5-7 illegal
is_double_i  in  1  DP op (selects DIV latency)
rob_id_i  in  ROB_W  tag
phys_dest_i  in  PREG_W  tag
ready_o  out  1  combinational accept
flush_i  in  1  kill all in-flight ops
div_start_o  out  1  one-cycle pulse starting the div/sqrt datapath
res_misc_i/res_add_i/res_mul_i/res_fma_i/res_div_i  in  DATA_W each  unit results, valid in their completion cycle
flags_misc_i/flags_add_i/flags_mul_i/flags_fma_i/flags_div_i  in  5 each  fflags {NV,DZ,OF,UF,NX}
wb_valid_o  out  1  writeback strobe
result_o  out  DATA_W  result
fflags_o  out  5  flags
rob_id_o  out  ROB_W  tag
phys_dest_o  out  PREG_W  tag

Behaviour:
- Reset (async, rst_n=0): all slots empty, divider IDLE, wb_valid_o=0, result_o=0, fflags_o=0, rob_id_o=0, phys_dest_o=0, div_start_o=0.
- Slot array occ[1..MAXL], each entry holding {class, rob_id, phys_dest}. Every edge, slot k+1 moves to slot k; slot 1 drains to the output registers.
- Accept = valid_i & ready_o & !flush_i. An accepted pipelined op of latency L is written into slot L (post-shift). wb_valid_o is high in the cycle after edge t+L-1, i.e. L cycles after acceptance. Example: accept at edge 0, LAT_ADD=3, wb_valid_o is visible after edge 3.
- ready_o for a pipelined class = slot L+1 currently empty (that is, free after the shift). MAXL+1 counts as always empty.
- ready_o for the DIV class = divider IDLE. Classes 5-7: ready_o=0.
- Divider FSM:
  - IDLE -> BUSY on DIV accept; div_start_o=1 on that edge; counter loads DIV_LAT_DP-1 or DIV_LAT_SP-1.
  - BUSY decrements the counter; at 0 it moves to DONE.
  - DONE holds the tag until slot 1 is empty, then the divider result is written back and the FSM returns to IDLE.
  - Minimum latency is accept + DIV_LAT. Pipelined ops always win the writeback cycle; the div unit must hold res_div_i/flags_div_i while DONE.
- Output stage: on each edge, if slot 1 is occupied, register wb_valid_o=1, the tags, and result/flags muxed by the slot's class. Otherwise, if div is DONE, register the div result. Otherwise wb_valid_o=0, and the other outputs hold their previous values.
- Pipelined ops and div ops may be issued back-to-back in consecutive cycles whenever no slot conflicts.
- flush_i: on that edge clear all slots and force the divider to IDLE. An offer in the same cycle is not accepted. wb_valid_o=0 from the next cycle onward. A writeback already registered in the current cycle is still visible this cycle.

Optional Feature:
FPU_WB_STALL_CNT_EN: when defined, adds output ports stall_cnt_o (32) and div_busy_cnt_o (32).
- stall_cnt_o increments each cycle valid_i & !ready_o.
- div_busy_cnt_o increments each cycle the divider is not IDLE.
- Both counters saturate at 32'hFFFF_FFFF and reset to 0.
- When the macro is undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset mid-operation: ADD accepted, rst_n low at the next cycle -> all outputs 0 and no wb_valid_o after release; ready_o=1 for every legal class.
- Single ADD at cycle 0, rob_id=5, phys_dest=0x21, res_add_i=0x3FF0_0000_0000_0000 -> wb_valid_o=1 at cycle 3 with those exact values, and wb_valid_o low in every other cycle.
- Conflict: MUL at cycle 0, then ADD at cycle 1 -> both would complete at cycle 4, so ready_o=0 for the ADD; the ADD is accepted at cycle 2 -> wb order is MUL@4, ADD@5.
- Back-to-back ops: MISC at cycles 0..3 -> wb_valid_o high cycles 1..4, rob_ids in issue order.
- DP DIV at cycle 0 and FMA at cycle 12 (completes at 17) -> div_start_o pulse at 0, ready_o=0 for a DIV offered at cycle 5, FMA writes back at 17, DIV writes back at 18.
- Flush at cycle 2 with ADD (from 0) and SP DIV (from 1) in flight -> no wb_valid_o afterwards; a DIV offered at cycle 3 is accepted (ready_o=1).
